baser_257b_serializer: RTL and testbench

// - Receive side of the BASE-R 257b path: accepts one 257b transcoded word per valid/ready beat and decodes it into four 66b blocks.
// - Buffers decoded words in a FIFO and emits one 66b block per beat on a valid/ready output.
// - Sits between the 257b link interface and the 66b block checker, which needs a serial 66b stream.

---
 rtl/baser_257b_serializer.sv | 240 ++++++++++++++++++++++++
 tb/tb_baser_257b_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/baser_257b_serializer.sv
// ---------------------------------------------------------------------------
// baser_257b_serializer
//
// Receive-side BASE-R 257b -> 66b serializer. Each accepted 257b transcoded
// word is registered, decoded into four 66b blocks (sync header in [1:0]) and
// written into a small FIFO. Blocks leave one per output handshake in order
// 0..3; the FIFO entry is popped when block 3 is consumed.
//
// Ports
//   clk              clock
//   i_rst            asynchronous reset, active-high
//   i_valid/o_ready  input handshake for i_rx_xcoded (257b word)
//   o_valid/i_ready  output handshake for o_rx_coded (66b block)
//   o_err            current block comes from an invalid transcoded word
//   o_word_count     accepted words       (saturating)
//   o_inv_word_count invalid words        (saturating)
//   o_blk_count      output handshakes    (saturating)
//
// Build option
//   BASER_SER_STATS_EN  when defined the three statistics counters exist;
//                       otherwise the counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module baser_257b_serializer #(
    parameter int         DATA_WIDTH        = 64,
    parameter int         HDR_WIDTH         = 2,
    parameter int         FRAME_WIDTH       = DATA_WIDTH + HDR_WIDTH,
    parameter int         TC_WIDTH          = 4 * DATA_WIDTH + 1,
    parameter int         FIFO_DEPTH        = 4,
    parameter logic [6:0] CTRL_CHAR_PATTERN = 7'h1E
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [TC_WIDTH-1:0]    i_rx_xcoded,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [FRAME_WIDTH-1:0] o_rx_coded,
    output logic                   o_err,
    output logic [31:0]            o_word_count,
    output logic [31:0]            o_inv_word_count,
    output logic [31:0]            o_blk_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef logic [3:0][FRAME_WIDTH-1:0] blocks_t;

    typedef struct packed {
        logic    err;
        blocks_t blk;
    } entry_t;

    // 4-bit transcoded type nibble to full 8-bit block type; 0 is not a valid nibble.
    function automatic logic [7:0] nib_to_type(input logic [3:0] nib);
        logic [7:0] t;
        case (nib)
            4'hE: t = 8'h1E;
            4'hD: t = 8'h2D;
            4'h3: t = 8'h33;
            4'hB: t = 8'h4B;
            4'h5: t = 8'h55;
            4'h6: t = 8'h66;
            4'h8: t = 8'h78;
            4'h7: t = 8'h87;
            4'h9: t = 8'h99;
            4'hA: t = 8'hAA;
            4'h4: t = 8'hB4;
            4'hC: t = 8'hCC;
            4'h2: t = 8'hD2;
            4'h1: t = 8'hE1;
            4'hF: t = 8'hFF;
            default: t = 8'h00;
        endcase
        return t;
    endfunction

    function automatic entry_t decode_word(input logic [TC_WIDTH-1:0] w);
        entry_t     e;
        logic [3:0] flags;
        logic       first_seen;
        int         pos;
        logic [63:0] err_fill;
        logic [FRAME_WIDTH-1:0] err_blk;

        err_fill   = {8{CTRL_CHAR_PATTERN, 1'b0}};
        err_blk    = {err_fill[55:0], 8'h1E, 2'b10};
        flags      = w[4:1];
        first_seen = 1'b0;
        pos        = 5;
        e.err      = 1'b0;
        e.blk      = '0;

        if (w[0]) begin
            for (int k = 0; k < 4; k++)
                e.blk[k] = {w[DATA_WIDTH*k+1 +: DATA_WIDTH], 2'b01};
        end else if (flags == 4'hF) begin
            // All-data flags with a control header cannot be a legal word.
            e.err = 1'b1;
        end else begin
            // Payload is packed in block order; only the first control block
            // is compressed to a 4-bit type nibble.
            for (int k = 0; k < 4; k++) begin
                if (flags[k]) begin
                    e.blk[k] = {w[pos +: 64], 2'b01};
                    pos += 64;
                end else if (!first_seen) begin
                    first_seen = 1'b1;
                    if (w[pos +: 4] == 4'h0)
                        e.err = 1'b1;
                    e.blk[k] = {w[pos+4 +: 56], nib_to_type(w[pos +: 4]), 2'b10};
                    pos += 60;
                end else begin
                    e.blk[k] = {w[pos+8 +: 56], w[pos +: 8], 2'b10};
                    pos += 64;
                end
            end
        end

        if (e.err)
            e.blk = {4{err_blk}};
        return e;
    endfunction

    logic                   running;
    logic                   accept;
    logic                   out_hs;
    logic                   pop;
    logic [CNT_W-1:0]       occ;
    logic [CNT_W-1:0]       cnt;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [1:0]             idx;
    logic [FRAME_WIDTH-1:0] last_blk;
    logic [FRAME_WIDTH-1:0] cur_blk;

    logic [TC_WIDTH-1:0]    word_p0;
    logic                   vld_p0;
    entry_t                 entry_p1;
    entry_t                 mem [FIFO_DEPTH];

    // occ reserves a FIFO slot at acceptance so a word sitting in the decode
    // register always has room when it lands.
    assign o_ready = running && (occ != DEPTH_C);
    assign accept  = i_valid && o_ready;
    assign o_valid = (cnt != '0);
    assign out_hs  = o_valid && i_ready;
    assign pop     = out_hs && (idx == 2'd3);

    assign cur_blk    = mem[rd_ptr].blk[idx];
    assign o_rx_coded = o_valid ? cur_blk : last_blk;
    assign o_err      = o_valid && mem[rd_ptr].err;

    // ---- stage p0: capture accepted word ----
    always_ff @(posedge clk)
        if (accept)
            word_p0 <= i_rx_xcoded;

    // ---- stage p1: decode and write FIFO ----
    assign entry_p1 = decode_word(word_p0);

    always_ff @(posedge clk)
        if (vld_p0)
            mem[wr_ptr] <= entry_p1;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            running  <= 1'b0;
            vld_p0   <= 1'b0;
            occ      <= '0;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx      <= 2'd0;
            last_blk <= '0;
        end else begin
            running <= 1'b1;
            vld_p0  <= accept;

            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            case ({vld_p0, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            if (vld_p0)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            // ---- output: block index walks 0..3 per handshake ----
            if (out_hs) begin
                idx      <= idx + 2'd1;
                last_blk <= cur_blk;
            end
        end
    end

`ifdef BASER_SER_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] word_count;
    logic [31:0] inv_count;
    logic [31:0] blk_count;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            word_count <= '0;
            inv_count  <= '0;
            blk_count  <= '0;
        end else begin
            if (accept)
                word_count <= sat_inc(word_count);
            if (vld_p0 && entry_p1.err)
                inv_count <= sat_inc(inv_count);
            if (out_hs)
                blk_count <= sat_inc(blk_count);
        end
    end

    assign o_word_count     = word_count;
    assign o_inv_word_count = inv_count;
    assign o_blk_count      = blk_count;
`else
    assign o_word_count     = 32'd0;
    assign o_inv_word_count = 32'd0;
    assign o_blk_count      = 32'd0;
`endif

endmodule

// File: tb/tb_baser_257b_serializer.sv
// ---------------------------------------------------------------------------
// tb_baser_257b_serializer
//
// Directed bench for baser_257b_serializer: reset state, all-data word,
// mixed control/data words, invalid words, FIFO full / simultaneous push-pop,
// mid-stream reset. Counter expectations follow BASER_SER_STATS_EN.
// ---------------------------------------------------------------------------
module tb_baser_257b_serializer;

`ifdef BASER_SER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [65:0] AA_DATA = {64'hAAAA_AAAA_AAAA_AAAA, 2'b01};
    localparam logic [65:0] ERR_BLK = {56'h3C3C3C3C3C3C3C, 8'h1E, 2'b10};

    logic         clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [256:0] i_rx_xcoded;
    logic         o_valid;
    logic         i_ready;
    logic [65:0]  o_rx_coded;
    logic         o_err;
    logic [31:0]  o_word_count;
    logic [31:0]  o_inv_word_count;
    logic [31:0]  o_blk_count;

    int checks = 0;
    int errors = 0;
    int exp_words = 0;
    int exp_inv = 0;
    int exp_blks = 0;

    baser_257b_serializer dut (
        .clk              (clk),
        .i_rst            (i_rst),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_rx_xcoded      (i_rx_xcoded),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_rx_coded       (o_rx_coded),
        .o_err            (o_err),
        .o_word_count     (o_word_count),
        .o_inv_word_count (o_inv_word_count),
        .o_blk_count      (o_blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] exp_cnt(input int v);
        return STATS ? 66'(v) : 66'd0;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, " word_count"}, 66'(o_word_count), exp_cnt(exp_words));
        check({tag, " inv_count"}, 66'(o_inv_word_count), exp_cnt(exp_inv));
        check({tag, " blk_count"}, 66'(o_blk_count), exp_cnt(exp_blks));
    endtask

    // Word id -> all-data word whose block k carries byte 16*id+k everywhere.
    function automatic logic [256:0] mk_data(input int id);
        logic [256:0] w;
        w    = '0;
        w[0] = 1'b1;
        for (int k = 0; k < 4; k++)
            w[64*k+1 +: 64] = {8{8'(16*id + k)}};
        return w;
    endfunction

    function automatic logic [65:0] data_blk(input int id, input int k);
        return {{8{8'(16*id + k)}}, 2'b01};
    endfunction

    task automatic send_word(input logic [256:0] w);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        i_rx_xcoded = w;
        i_valid = 1'b1;
        while (!acc && n < 50) begin
            acc = o_ready;
            @(posedge clk); #1;
            n++;
        end
        i_valid = 1'b0;
        check("send accepted", 66'(acc), 66'd1);
        exp_words++;
    endtask

    task automatic expect_block(input string tag, input logic [65:0] eblk, input logic eerr);
        int n;
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " valid"}, 66'(o_valid), 66'd1);
        check(tag, o_rx_coded, eblk);
        check({tag, " err"}, 66'(o_err), 66'(eerr));
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        exp_blks++;
    endtask

    initial begin
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_rx_xcoded = '0;

        // Reset state
        #200;
        check("rst o_valid", 66'(o_valid), 66'd0);
        check("rst o_ready", 66'(o_ready), 66'd0);
        check("rst o_rx_coded", o_rx_coded, 66'd0);
        check("rst o_err", 66'(o_err), 66'd0);
        check_counters("rst");
        i_rst = 1'b0;
        @(posedge clk); #1;
        check("ready after rst", 66'(o_ready), 66'd1);

        // All-data word, latency and hold-when-empty
        send_word({{32{8'hAA}}, 1'b1});
        check("lat p0 not valid", 66'(o_valid), 66'd0);
        @(posedge clk); #1;
        check("lat valid", 66'(o_valid), 66'd1);
        for (int k = 0; k < 4; k++)
            expect_block("aa data", AA_DATA, 1'b0);
        check("empty o_valid", 66'(o_valid), 66'd0);
        check("empty holds last", o_rx_coded, AA_DATA);
        check_counters("t1");

        // Control block 0 with nibble 8, data blocks 1..3
        send_word({{24{8'hAA}}, {7{8'hAA}}, 4'h8, 4'b1110, 1'b0});
        expect_block("ctl b0", {56'hAAAAAAAAAAAAAA, 8'h78, 2'b10}, 1'b0);
        for (int k = 1; k < 4; k++)
            expect_block("ctl data", AA_DATA, 1'b0);

        // Two control blocks: compressed nibble then full type byte
        send_word({56'hA1A2A3A4A5A6A7, 8'h33, 64'hFEDCBA9876543210,
                   56'h11223344556677, 4'h4, 64'h0123456789ABCDEF, 4'b0101, 1'b0});
        expect_block("mix b0", {64'h0123456789ABCDEF, 2'b01}, 1'b0);
        expect_block("mix b1", {56'h11223344556677, 8'hB4, 2'b10}, 1'b0);
        expect_block("mix b2", {64'hFEDCBA9876543210, 2'b01}, 1'b0);
        expect_block("mix b3", {56'hA1A2A3A4A5A6A7, 8'h33, 2'b10}, 1'b0);

        // Invalid: control header with all-data flags
        send_word({{31{8'h55}}, 4'h0, 4'hF, 1'b0});
        exp_inv++;
        for (int k = 0; k < 4; k++)
            expect_block("inv flags", ERR_BLK, 1'b1);

        // Invalid: zero type nibble in block 3
        send_word({56'h0123456789ABCD, 4'h0, {24{8'h11}}, 4'b0111, 1'b0});
        exp_inv++;
        for (int k = 0; k < 4; k++)
            expect_block("inv nibble", ERR_BLK, 1'b1);
        check_counters("t3");

        // Fill FIFO with no consumer
        for (int i = 1; i <= 4; i++)
            send_word(mk_data(i));
        check("full o_ready", 66'(o_ready), 66'd0);
        repeat (3) @(posedge clk);
        #1;
        check("full hold valid", 66'(o_valid), 66'd1);
        check("full hold blk", o_rx_coded, data_blk(1, 0));
        check("still full", 66'(o_ready), 66'd0);
        for (int k = 0; k < 4; k++)
            expect_block("drain w1", data_blk(1, k), 1'b0);
        check("ready after pop", 66'(o_ready), 66'd1);
        for (int k = 0; k < 3; k++)
            expect_block("drain w2", data_blk(2, k), 1'b0);

        // Same-cycle push and pop of block 3
        check("pre pushpop blk", o_rx_coded, data_blk(2, 3));
        i_rx_xcoded = mk_data(5);
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        exp_words++;
        exp_blks++;
        check("pushpop o_ready", 66'(o_ready), 66'd1);
        for (int i = 3; i <= 5; i++)
            for (int k = 0; k < 4; k++)
                expect_block("drain order", data_blk(i, k), 1'b0);
        check("drained", 66'(o_valid), 66'd0);
        check_counters("t4");

        // Reset with two words queued
        send_word(mk_data(6));
        send_word(mk_data(7));
        @(posedge clk); #1;
        check("queued valid", 66'(o_valid), 66'd1);
        i_rst = 1'b1;
        #1;
        exp_words = 0;
        exp_inv = 0;
        exp_blks = 0;
        check("midrst o_valid", 66'(o_valid), 66'd0);
        check("midrst o_ready", 66'(o_ready), 66'd0);
        check_counters("midrst");
        #20;
        i_rst = 1'b0;
        @(posedge clk); #1;
        check("post rst ready", 66'(o_ready), 66'd1);
        send_word(mk_data(8));
        expect_block("post rst b0", data_blk(8, 0), 1'b0);
        expect_block("post rst b1", data_blk(8, 1), 1'b0);
        check_counters("post rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
